// File: rtl/alu_master.sv
// alu_master: drains the instruction FIFO, executes each instruction on register-file
// operands and pushes results to the result FIFO, reporting done/err to the slave.
module alu_master #(
    parameter int ACK_TIMEOUT = 16,
    parameter int MUL_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        alu_begin,
    input  logic        instruction_empty,
    output logic        i_pop,
    input  logic        i_rd_ack,
    input  logic        i_rd_err,
    input  logic [31:0] i_dout,
    output logic [3:0]  rAddr0,
    output logic [3:0]  rAddr1,
    input  logic [31:0] rData0,
    input  logic [31:0] rData1,
    output logic        r_push,
    output logic [31:0] r_din,
    input  logic        r_wr_ack,
    input  logic        r_wr_err,
    output logic        alu_done,
    output logic        alu_err,
    output logic [7:0]  instr_count
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int MW = $clog2(MUL_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [MW-1:0] MUL_LAST = MW'(MUL_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_POP, S_WAIT_I, S_FETCH, S_EXEC, S_MULT,
        S_PUSH, S_WAIT_R, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t         r_state;
    logic [3:0]     r_op;
    logic [31:0]    r_a;
    logic [31:0]    r_b;
    logic [31:0]    r_acc;
    logic [TW-1:0]  r_tmo;
    logic [MW-1:0]  r_mcnt;
    logic [31:0]    w_res;
    logic [31:0]    w_acc_next;
    logic           w_tmo_exp;
    logic           w_unused;

    assign w_unused   = ^i_dout[31:12];
    assign w_tmo_exp  = (r_tmo == TMO_LAST);
    // Shift-add step: r_a is the shifted multiplicand, r_b the shifted multiplier.
    assign w_acc_next = r_b[0] ? r_acc + r_a : r_acc;

    always_comb begin
        w_res = '0;
        case (r_op)
            4'd1:    w_res = r_a + r_b;
            4'd2:    w_res = r_a - r_b;
            4'd3:    w_res = r_a & r_b;
            4'd4:    w_res = r_a | r_b;
            4'd5:    w_res = r_a ^ r_b;
            4'd6:    w_res = ~r_a;
            4'd7:    w_res = r_a << r_b[4:0];
            4'd8:    w_res = r_a >> r_b[4:0];
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            i_pop       <= 1'b0;
            r_push      <= 1'b0;
            r_din       <= '0;
            rAddr0      <= '0;
            rAddr1      <= '0;
            alu_done    <= 1'b0;
            alu_err     <= 1'b0;
            instr_count <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_tmo       <= '0;
            r_mcnt      <= '0;
        end else begin
            i_pop  <= 1'b0;
            r_push <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    instr_count <= '0;
                    if (alu_begin && instruction_empty) begin
                        r_state  <= S_DONE;
                        alu_done <= 1'b1;
                    end else if (alu_begin) begin
                        r_state <= S_POP;
                        i_pop   <= 1'b1;
                    end
                end
                S_POP: begin
                    r_state <= S_WAIT_I;
                    r_tmo   <= '0;
                end
                S_WAIT_I: begin
                    r_tmo <= r_tmo + 1'b1;
                    if (i_rd_err || (!i_rd_ack && w_tmo_exp)) begin
                        r_state  <= S_ERR;
                        alu_done <= 1'b1;
                        alu_err  <= 1'b1;
                    end else if (i_rd_ack) begin
                        r_op    <= i_dout[11:8];
                        rAddr0  <= i_dout[7:4];
                        rAddr1  <= i_dout[3:0];
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_a     <= rData0;
                    r_b     <= rData1;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (r_op == 4'd0) begin
                        r_state <= S_NEXT;
                    end else if (r_op == 4'd9) begin
                        r_state <= S_MULT;
                        r_acc   <= '0;
                        r_mcnt  <= '0;
                    end else if (r_op > 4'd9) begin
                        r_state  <= S_ERR;
                        alu_done <= 1'b1;
                        alu_err  <= 1'b1;
                    end else begin
                        r_din   <= w_res;
                        r_push  <= 1'b1;
                        r_state <= S_PUSH;
                    end
                end
                S_MULT: begin
                    r_acc  <= w_acc_next;
                    r_a    <= r_a << 1;
                    r_b    <= r_b >> 1;
                    r_mcnt <= r_mcnt + 1'b1;
                    if (r_mcnt == MUL_LAST) begin
                        r_din   <= w_acc_next;
                        r_push  <= 1'b1;
                        r_state <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    r_state <= S_WAIT_R;
                    r_tmo   <= '0;
                end
                S_WAIT_R: begin
                    r_tmo <= r_tmo + 1'b1;
                    if (r_wr_err || (!r_wr_ack && w_tmo_exp)) begin
                        r_state  <= S_ERR;
                        alu_done <= 1'b1;
                        alu_err  <= 1'b1;
                    end else if (r_wr_ack) begin
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    instr_count <= instr_count + 1'b1;
                    if (instruction_empty) begin
                        r_state  <= S_DONE;
                        alu_done <= 1'b1;
                    end else begin
                        r_state <= S_POP;
                        i_pop   <= 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    if (!alu_begin) begin
                        r_state     <= S_IDLE;
                        alu_done    <= 1'b0;
                        alu_err     <= 1'b0;
                        instr_count <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
